// File: rtl/nand_cell_stim_checker.sv
// Stimulus generator and checker for a 2-input NAND cell under test.
// Optional macro NAND_STIM_LFSR_EN selects LFSR vectors instead of the ordered 00..11 sweep.
module nand_cell_stim_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ITER_W        = 8,
  parameter int unsigned ERR_W         = 8
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              START,
  input  logic [ITER_W-1:0] ITERATIONS,
  input  logic              Y_IN,
  output logic              A_OUT,
  output logic              B_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [ERR_W-1:0]  ERR_COUNT,
  output logic [ITER_W+1:0] VEC_COUNT
);

  localparam int unsigned VEC_W = ITER_W + 2;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_FIN
  } state_t;

  state_t             r_state, w_state_d;
  logic [ITER_W-1:0]  r_iter, w_iter_d;
  logic [SET_W-1:0]   r_cnt, w_cnt_d;
  logic               r_a, w_a_d;
  logic               r_b, w_b_d;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;
  logic               r_pass, w_pass_d;
  logic [ERR_W-1:0]   r_err, w_err_d;
  logic [VEC_W-1:0]   r_vcnt, w_vcnt_d;
  logic [VEC_W-1:0]   w_vcnt_inc;
  logic               w_mismatch;
  logic               w_seed;
  logic               w_adv;
  logic [1:0]         w_vec;

  assign w_vcnt_inc = r_vcnt + VEC_W'(1);
  assign w_mismatch = (Y_IN != ~(r_a & r_b));

  // Vector source: seeded on an accepted START, advanced after each non-final sample
`ifdef NAND_STIM_LFSR_EN
  logic [3:0] r_lfsr, w_lfsr_d;

  always_comb begin
    w_lfsr_d = r_lfsr;
    if (w_seed)
      w_lfsr_d = 4'b0001;
    else if (w_adv)
      w_lfsr_d = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
  end

  always_ff @(posedge CLK) begin
    if (!RN) r_lfsr <= 4'b0001;
    else     r_lfsr <= w_lfsr_d;
  end

  assign w_vec = r_lfsr[1:0];
`else
  logic [1:0] r_idx, w_idx_d;

  always_comb begin
    w_idx_d = r_idx;
    if (w_seed)
      w_idx_d = 2'b00;
    else if (w_adv)
      w_idx_d = r_idx + 2'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RN) r_idx <= 2'b00;
    else     r_idx <= w_idx_d;
  end

  assign w_vec = r_idx;
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_d = r_state;
    w_iter_d  = r_iter;
    w_cnt_d   = r_cnt;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_busy_d  = r_busy;
    w_done_d  = r_done;
    w_pass_d  = r_pass;
    w_err_d   = r_err;
    w_vcnt_d  = r_vcnt;
    w_seed    = 1'b0;
    w_adv     = 1'b0;

    case (r_state)
      S_IDLE, S_FIN: begin
        if (r_state == S_FIN) begin
          w_busy_d = 1'b0;
          w_done_d = 1'b1;
          w_pass_d = (r_err == ERR_W'(0));
        end
        if (START) begin
          w_iter_d  = ITERATIONS;
          w_err_d   = '0;
          w_vcnt_d  = '0;
          w_done_d  = 1'b0;
          w_pass_d  = 1'b0;
          w_busy_d  = 1'b0;
          w_seed    = 1'b1;
          w_state_d = (ITERATIONS == ITER_W'(0)) ? S_FIN : S_APPLY;
        end
      end

      S_APPLY: begin
        w_a_d     = w_vec[1];
        w_b_d     = w_vec[0];
        w_busy_d  = 1'b1;
        w_cnt_d   = '0;
        w_state_d = S_SETTLE;
      end

      S_SETTLE: begin
        if (r_cnt == SET_W'(SETTLE_CYCLES - 1))
          w_state_d = S_SAMPLE;
        else
          w_cnt_d = r_cnt + SET_W'(1);
      end

      S_SAMPLE: begin
        if (w_mismatch && (r_err != {ERR_W{1'b1}}))
          w_err_d = r_err + ERR_W'(1);
        w_vcnt_d = w_vcnt_inc;
        if (w_vcnt_inc == {r_iter, 2'b00}) begin
          w_state_d = S_FIN;
        end else begin
          w_adv     = 1'b1;
          w_state_d = S_APPLY;
        end
      end

      default: w_state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_cnt   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_vcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_iter  <= w_iter_d;
      r_cnt   <= w_cnt_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_pass  <= w_pass_d;
      r_err   <= w_err_d;
      r_vcnt  <= w_vcnt_d;
    end
  end

  assign A_OUT     = r_a;
  assign B_OUT     = r_b;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign ERR_COUNT = r_err;
  assign VEC_COUNT = r_vcnt;

endmodule

// File: tb/tb_nand_cell_stim_checker.sv
// Directed bench for nand_cell_stim_checker with an ideal or stuck-at NAND model on Y_IN.
module tb_nand_cell_stim_checker;

  localparam int unsigned ITER_W = 8;
  localparam int unsigned ERR_W  = 8;

  logic              CLK = 1'b0;
  logic              RN;
  logic              START;
  logic [ITER_W-1:0] ITERATIONS;
  logic              Y_IN;
  logic              A_OUT, B_OUT, BUSY, DONE, PASS;
  logic [ERR_W-1:0]  ERR_COUNT;
  logic [ITER_W+1:0] VEC_COUNT;

  int n_cmp  = 0;
  int n_fail = 0;
  int mode   = 0;   // 0 ideal, 1 stuck-at-1, 2 stuck-at-0

  always #5 CLK = ~CLK;

  assign Y_IN = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ~(A_OUT & B_OUT);

  nand_cell_stim_checker #(
    .SETTLE_CYCLES(2),
    .ITER_W       (ITER_W),
    .ERR_W        (ERR_W)
  ) dut (
    .CLK       (CLK),
    .RN        (RN),
    .START     (START),
    .ITERATIONS(ITERATIONS),
    .Y_IN      (Y_IN),
    .A_OUT     (A_OUT),
    .B_OUT     (B_OUT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .PASS      (PASS),
    .ERR_COUNT (ERR_COUNT),
    .VEC_COUNT (VEC_COUNT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected {A,B} for the k-th vector of a run
  function automatic logic [1:0] exp_vec(input int k);
    logic [3:0] l;
    l = 4'b0001;
`ifdef NAND_STIM_LFSR_EN
    for (int i = 0; i < k; i++) l = {l[2:0], l[3] ^ l[2]};
    return l[1:0];
`else
    return 2'(k % 4);
`endif
  endfunction

  function automatic int exp_err(input int nvec, input int m);
    int e;
    logic [1:0] v;
    logic y;
    e = 0;
    for (int k = 0; k < nvec; k++) begin
      v = exp_vec(k);
      y = (m == 1) ? 1'b1 : (m == 2) ? 1'b0 : ~(v[1] & v[0]);
      if (y != ~(v[1] & v[0]) && e < 255) e++;
    end
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input int n);
    @(negedge CLK);
    START = 1'b1;
    ITERATIONS = ITER_W'(n);
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!DONE && c < budget) begin
      step(1);
      c++;
    end
    check("done_within_budget", 32'(DONE), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},    32'(A_OUT), 0);
    check({tag, "_b"},    32'(B_OUT), 0);
    check({tag, "_busy"}, 32'(BUSY), 0);
    check({tag, "_done"}, 32'(DONE), 0);
    check({tag, "_pass"}, 32'(PASS), 0);
    check({tag, "_err"},  32'(ERR_COUNT), 0);
    check({tag, "_vcnt"}, 32'(VEC_COUNT), 0);
  endtask

  initial begin
    RN = 1'b0;
    START = 1'b0;
    ITERATIONS = '0;

    // Reset state
    step(3);
    check_all_zero("reset");
    @(negedge CLK);
    RN = 1'b1;

    // Ideal CUT, 3 iterations: vector order, busy window and DONE at cycle 49
    mode = 0;
    do_start(3);
    check("ideal_busy_before_apply", 32'(BUSY), 0);
    for (int k = 0; k < 12; k++) begin
      step((k == 0) ? 1 : 4);
      check($sformatf("ideal_vec%0d", k), 32'({A_OUT, B_OUT}), 32'(exp_vec(k)));
    end
    check("ideal_busy_mid", 32'(BUSY), 1);
    step(3);
    check("ideal_done_c48", 32'(DONE), 0);
    check("ideal_busy_c48", 32'(BUSY), 1);
    step(1);
    check("ideal_done_c49", 32'(DONE), 1);
    check("ideal_busy_c49", 32'(BUSY), 0);
    check("ideal_pass", 32'(PASS), 1);
    check("ideal_err", 32'(ERR_COUNT), 0);
    check("ideal_vcnt", 32'(VEC_COUNT), 12);

    // Y stuck at 1: only the {1,1} vectors mismatch
    mode = 1;
    do_start(3);
    check("st1_done_cleared", 32'(DONE), 0);
    wait_done(100);
    check("st1_err", 32'(ERR_COUNT), 32'(exp_err(12, 1)));
    check("st1_pass", 32'(PASS), 0);
    check("st1_vcnt", 32'(VEC_COUNT), 12);

    // Zero iterations: finish on the next cycle without raising BUSY
    mode = 0;
    do_start(0);
    check("it0_done_c0", 32'(DONE), 0);
    check("it0_busy_c0", 32'(BUSY), 0);
    step(1);
    check("it0_done_c1", 32'(DONE), 1);
    check("it0_pass", 32'(PASS), 1);
    check("it0_vcnt", 32'(VEC_COUNT), 0);
    check("it0_busy_c1", 32'(BUSY), 0);

    // Y stuck at 0 for 100 iterations: error counter saturates
    mode = 2;
    do_start(100);
    wait_done(2000);
    check("st0_err_sat", 32'(ERR_COUNT), 32'(exp_err(400, 2)));
    check("st0_pass", 32'(PASS), 0);
    check("st0_vcnt", 32'(VEC_COUNT), 400);

    // START mid-run is ignored: run of 2 iterations still ends at cycle 33
    mode = 0;
    do_start(2);
    step(9);
    @(negedge CLK);
    START = 1'b1;
    ITERATIONS = ITER_W'(5);
    step(1);
    START = 1'b0;
    step(22);
    check("mid_done_c32", 32'(DONE), 0);
    step(1);
    check("mid_done_c33", 32'(DONE), 1);
    check("mid_vcnt", 32'(VEC_COUNT), 8);
    check("mid_pass", 32'(PASS), 1);

    // Reset mid-run abandons the run
    mode = 2;
    do_start(3);
    step(10);
    check("rst_mid_err_before", 32'(ERR_COUNT), 2);
    @(negedge CLK);
    RN = 1'b0;
    step(1);
    check_all_zero("rst_mid");
    @(negedge CLK);
    RN = 1'b1;
    step(6);
    check("rst_mid_idle_busy", 32'(BUSY), 0);
    check("rst_mid_idle_done", 32'(DONE), 0);

    // START together with reset: reset wins
    @(negedge CLK);
    RN = 1'b0;
    START = 1'b1;
    ITERATIONS = ITER_W'(3);
    step(1);
    @(negedge CLK);
    RN = 1'b1;
    START = 1'b0;
    step(3);
    check("rst_start_busy", 32'(BUSY), 0);
    check("rst_start_done", 32'(DONE), 0);
    check("rst_start_vcnt", 32'(VEC_COUNT), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
